// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I opcodes, instruction formats and field widths
package rv32i_pkg;
  localparam int OP_W = 7;
  localparam int F3_W = 3;
  localparam int F7_W = 7;
  localparam int REG_W = 5;
  localparam int IMM_W = 20;
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_FENCE  = 7'b0001111;
  localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_t;
  function automatic fmt_t fmt_of(input logic [OP_W-1:0] op);
    case (op)
      OP_R: return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: return FMT_I;
      OP_STORE: return FMT_S;
      OP_BRANCH: return FMT_B;
      OP_LUI, OP_AUIPC: return FMT_U;
      OP_JAL: return FMT_J;
      default: return FMT_BAD;
    endcase
  endfunction
endpackage

// File: rtl/ins_dec_fields.sv
// ins_dec_fields: combinational split of an RV32I word into format-specific fields
module ins_dec_fields
  import rv32i_pkg::*;
(
  input  logic [31:0]      ins,
  output fmt_t             fmt,
  output logic [F3_W-1:0]  funct3,
  output logic [F7_W-1:0]  funct7,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd,
  output logic [IMM_W-1:0] imm
);
  always_comb begin
    fmt = fmt_of(ins[6:0]);
    funct3 = '0;
    funct7 = '0;
    rs1 = '0;
    rs2 = '0;
    rd = '0;
    imm = '0;
    case (fmt)
      FMT_R: begin
        funct3 = ins[14:12];
        funct7 = ins[31:25];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        rd = ins[11:7];
      end
      FMT_I: begin
        funct3 = ins[14:12];
        rs1 = ins[19:15];
        rd = ins[11:7];
        imm = {8'd0, ins[31:20]};
        // shift-immediates carry their funct7 in the upper immediate bits
        funct7 = (ins[6:0] == OP_IMM && ins[13:12] == 2'b01) ? ins[31:25] : '0;
      end
      FMT_S: begin
        funct3 = ins[14:12];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        imm = {8'd0, ins[31:25], ins[11:7]};
      end
      FMT_B: begin
        funct3 = ins[14:12];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        imm = {8'd0, ins[31], ins[7], ins[30:25], ins[11:8]};
      end
      FMT_U: begin
        rd = ins[11:7];
        imm = ins[31:12];
      end
      FMT_J: begin
        rd = ins[11:7];
        imm = {ins[31], ins[19:12], ins[20], ins[30:21]};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/ins_dec.sv
// ins_dec: registered RV32I field decoder; fields load on ins_vld and hold otherwise
module ins_dec
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ins_vld,
  input  logic [31:0] ins,
  output logic        dec_vld,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [19:0] imm,
  output logic        illegal
);
  fmt_t             fmt;
  logic [F3_W-1:0]  f3;
  logic [F7_W-1:0]  f7;
  logic [REG_W-1:0] s1, s2, d;
  logic [IMM_W-1:0] im;
  ins_dec_fields u_fields (
    .ins(ins), .fmt(fmt), .funct3(f3), .funct7(f7),
    .rs1(s1), .rs2(s2), .rd(d), .imm(im)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_vld <= 1'b0;
      op <= '0;
      funct3 <= '0;
      funct7 <= '0;
      rs1 <= '0;
      rs2 <= '0;
      rd <= '0;
      imm <= '0;
      illegal <= 1'b0;
    end else begin
      dec_vld <= ins_vld;
      if (ins_vld) begin
        op <= ins[6:0];
        funct3 <= f3;
        funct7 <= f7;
        rs1 <= s1;
        rs2 <= s2;
        rd <= d;
        imm <= im;
        illegal <= fmt == FMT_BAD;
      end
    end
  end
endmodule

// File: tb/tb_ins_dec.sv
// tb_ins_dec: directed and randomized checks of ins_dec against a reference model
module tb_ins_dec;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        ins_vld = 0;
  logic [31:0] ins = '0;
  logic        dec_vld, illegal;
  logic [6:0]  op, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [19:0] imm;
  int passed = 0, total = 0;
  logic [52:0] held = '0;

  ins_dec dut (
    .clk(clk), .rst_n(rst_n), .ins_vld(ins_vld), .ins(ins), .dec_vld(dec_vld),
    .op(op), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else passed++;
  endtask

  function automatic logic [63:0] obs();
    return {10'd0, dec_vld, op, funct3, funct7, rs1, rs2, rd, imm, illegal};
  endfunction

  // expected {op,funct3,funct7,rs1,rs2,rd,imm,illegal} from the ISA format rules
  function automatic logic [52:0] model(input logic [31:0] i);
    logic [6:0] o;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] a, b, d;
    logic [20:0] off;
    logic [19:0] im;
    logic bad;
    o = i[6:0];
    f3 = 0; f7 = 0; a = 0; b = 0; d = 0; im = 0; bad = 0; off = 0;
    if (o == 7'h33) begin
      f3 = i[14:12]; f7 = i[31:25]; a = i[19:15]; b = i[24:20]; d = i[11:7];
    end else if (o == 7'h13 || o == 7'h03 || o == 7'h67 || o == 7'h0F || o == 7'h73) begin
      f3 = i[14:12]; a = i[19:15]; d = i[11:7]; im = 20'(i[31:20]);
      if (o == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) f7 = i[31:25];
    end else if (o == 7'h23) begin
      f3 = i[14:12]; a = i[19:15]; b = i[24:20]; im = 20'({i[31:25], i[11:7]});
    end else if (o == 7'h63) begin
      f3 = i[14:12]; a = i[19:15]; b = i[24:20];
      off = 21'({i[31], i[7], i[30:25], i[11:8], 1'b0});
      im = 20'(off[12:1]);
    end else if (o == 7'h37 || o == 7'h17) begin
      d = i[11:7]; im = i[31:12];
    end else if (o == 7'h6F) begin
      d = i[11:7];
      off = {i[31], i[19:12], i[20], i[30:21], 1'b0};
      im = off[20:1];
    end else bad = 1;
    return {o, f3, f7, a, b, d, im, bad};
  endfunction

  task automatic dir(input string tag, input logic [31:0] i, input logic [52:0] exp);
    ins = i; ins_vld = 1;
    @(negedge clk);
    chk(tag, obs(), {10'd0, 1'b1, exp});
    held = exp;
  endtask

  logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  initial begin
    #12;
    chk("reset", obs(), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset_release", obs(), 64'd0);
    dir("add",  32'h003100B3, {7'b0110011, 3'b000, 7'b0000000, 5'd2, 5'd3, 5'd1, 20'h0, 1'b0});
    dir("sub",  32'h40418133, {7'b0110011, 3'b000, 7'b0100000, 5'd3, 5'd4, 5'd2, 20'h0, 1'b0});
    dir("xori", 32'hAAA14093, {7'b0010011, 3'b100, 7'b0, 5'd2, 5'd0, 5'd1, 20'h00AAA, 1'b0});
    dir("sw",   32'hAA20A523, {7'b0100011, 3'b010, 7'b0, 5'd1, 5'd2, 5'd0, 20'h00AAA, 1'b0});
    dir("bgeu", 32'hD420FA63, {7'b1100011, 3'b111, 7'b0, 5'd1, 5'd2, 5'd0, 20'h00AAA, 1'b0});
    dir("jal",  32'hD54550EF, {7'b1101111, 3'b0, 7'b0, 5'd0, 5'd0, 5'd1, 20'hAAAAA, 1'b0});
    dir("lui",  32'hAAAAA0B7, {7'b0110111, 3'b0, 7'b0, 5'd0, 5'd0, 5'd1, 20'hAAAAA, 1'b0});
    dir("srai", 32'h40515093, {7'b0010011, 3'b101, 7'b0100000, 5'd2, 5'd0, 5'd1, 20'h00405, 1'b0});
    dir("ill",  32'h0000007F, {7'b1111111, 3'b0, 7'b0, 5'd0, 5'd0, 5'd0, 20'h0, 1'b1});
    ins_vld = 0; ins = 32'h003100B3;
    @(negedge clk);
    chk("hold", obs(), {11'd0, held});
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      r = $urandom;
      ins_vld = ($urandom_range(3) != 0);
      ins = ($urandom_range(4) == 0) ? r : {r[31:7], ops[$urandom_range(10)]};
      if (ins_vld) held = model(ins);
      @(negedge clk);
      chk("rand", obs(), {10'd0, ins_vld, held});
      if (n == 200) begin
        #2 rst_n = 0;
        #1 chk("async_reset", obs(), 64'd0);
        @(negedge clk);
        rst_n = 1;
        held = '0;
        ins_vld = 0;
        @(negedge clk);
        chk("post_reset", obs(), 64'd0);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ins_dec.md
Name: ins_dec

Overview:
RV32I instruction field decoder in the decode stage, between instruction fetch and register-file read / ALU control.
- Splits a 32-bit instruction into op, funct3, funct7, rs1, rs2, rd and a raw, format-specific immediate.
- Zeroes every field the instruction's format does not define.
- Outputs are registered, so results appear one cycle after the instruction is presented.

Parameters:
None.

Ports:
clk      in   1   system clock, rising-edge active
rst_n    in   1   asynchronous active-low reset
ins_vld  in   1   ins is valid this cycle
ins      in   32  instruction word
dec_vld  out  1   decoded fields valid
op       out  7   opcode, ins[6:0]
funct3   out  3   3-bit function code
funct7   out  7   7-bit function code
rs1      out  5   source register 1 address
rs2      out  5   source register 2 address
rd       out  5   destination register address
imm      out  20  raw immediate, zero-extended, no scaling
illegal  out  1   opcode not in the RV32I base set

Behaviour:
- Reset: all outputs go to 0 asynchronously while rst_n=0. Clocked operation resumes on the first rising clk edge after release.
- Latency: one cycle. Decode is combinational from ins; all outputs register on rising clk.
- dec_vld <= ins_vld every cycle.
- Field registers load only when ins_vld=1 and otherwise hold their previous value.
- op = ins[6:0] for every instruction, including illegal ones.
- Fields not defined by the format are 0, and upper imm bits not filled by the format are 0. The immediate is never sign-extended; extension and scaling happen downstream.
- R (0110011):
  - funct3 = ins[14:12], funct7 = ins[31:25]
  - rs1 = ins[19:15], rs2 = ins[24:20], rd = ins[11:7]
  - imm = 0
- I (0010011, 0000011, 1100111, 0001111, 1110011):
  - funct3, rs1 and rd as above; rs2 = 0
  - imm[11:0] = ins[31:20]
  - funct7 = 0, except opcode 0010011 with funct3 001 or 101 (shifts), where funct7 = ins[31:25]. imm is still the full ins[31:20] in that case.
- S (0100011):
  - funct3, rs1 and rs2 as above; rd = 0, funct7 = 0
  - imm[11:0] = {ins[31:25], ins[11:7]}
- B (1100011):
  - funct3, rs1 and rs2 as above; rd = 0, funct7 = 0
  - imm[11:0] = {ins[31], ins[7], ins[30:25], ins[11:8]}, which is offset bits [12:1]
- U (0110111 LUI, 0010111 AUIPC):
  - rd as above; funct3, funct7, rs1 and rs2 = 0
  - imm = ins[31:12]
- J (1101111):
  - rd as above; all other fields 0
  - imm = {ins[31], ins[19:12], ins[20], ins[30:21]}, which is offset bits [20:1]
- Any other opcode: illegal = 1 and all fields except op are 0. illegal = 0 for the opcodes listed above.
- funct3/funct7 are not checked against the opcode: an unsupported funct combination under a legal opcode is passed through with illegal = 0.
- Reset asserted mid-operation clears the outputs immediately; no partial state survives.

Decomposition:
- Shared package (rv32i_pkg):
  - opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM
  - format enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD}
  - field width constants
- One combinational sub-module, ins_dec_fields: ins -> format and fields. ins_dec adds the output register stage and valid tracking.

Test Plan:
In every scenario, ins_vld = 1 with ins applied, and all checks are made one cycle later with dec_vld = 1.
- add x1,x2,x3: ins = 003100B3 -> op=0110011, funct3=000, funct7=0000000, rs1=2, rs2=3, rd=1, imm=0.
- sub x2,x3,x4: ins = 40418133 -> funct7=0100000, funct3=000, rs1=3, rs2=4, rd=2, imm=0.
- xori: ins = AAA14093 -> op=0010011, funct3=100, rs1=2, rd=1, rs2=0, funct7=0, imm=0x00AAA.
- sw: ins = AA20A523 -> op=0100011, funct3=010, rs1=1, rs2=2, rd=0, imm=0x00AAA.
- bgeu: ins = D420FA63 -> op=1100011, funct3=111, rs1=1, rs2=2, rd=0, imm=0x00AAA.
- jal: ins = D54550EF -> op=1101111, rd=1, others 0, imm=0xAAAAA.
- lui: ins = AAAAA0B7 -> op=0110111, rd=1, others 0, imm=0xAAAAA.
- illegal: ins = 0000007F -> illegal=1, fields 0.
- reset: asserting rst_n=0 mid-stream zeroes all outputs asynchronously.
